// File: rtl/rvvi_trace_arbiter.sv
// rvvi_trace_arbiter: per-hart retirement FIFOs merged round-robin into one registered trace stream
module rvvi_trace_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REC_W = 97,
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*REC_W-1:0]      req_rec_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [REC_W-1:0]              out_rec_o,
  output logic [$clog2(NUM_REQ)-1:0]    out_id_o,
  input  logic                          out_ready_i,
  output logic [NUM_REQ*16-1:0]         drop_cnt_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state_q, state_d;
  logic [REC_W-1:0] mem_q [NUM_REQ][DEPTH];
  logic [PW-1:0] wr_q [NUM_REQ];
  logic [PW-1:0] wr_d [NUM_REQ];
  logic [PW-1:0] rd_q [NUM_REQ];
  logic [PW-1:0] rd_d [NUM_REQ];
  logic [CW-1:0] cnt_q [NUM_REQ];
  logic [CW-1:0] cnt_d [NUM_REQ];
  logic [15:0] drop_q [NUM_REQ];
  logic [15:0] drop_d [NUM_REQ];
  logic [REC_W-1:0] out_rec_q, out_rec_d;
  logic [IDW-1:0] out_id_q, out_id_d, last_q, last_d, grant, idx;
  logic [NUM_REQ-1:0] nonempty, full, push, pop, drop;
  logic found, load;
  // Full is taken from the registered count so a same-cycle pop never opens a full FIFO.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      nonempty[k] = cnt_q[k] != '0;
      full[k] = cnt_q[k] == CW'(DEPTH);
      push[k] = req_valid_i[k] && !full[k] && !flush_i;
      drop[k] = req_valid_i[k] && full[k] && !flush_i;
      drop_cnt_o[k*16 +: 16] = drop_q[k];
    end
  end
  always_comb begin
    found = 1'b0;
    grant = last_q;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NUM_REQ);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  always_comb begin
    load = (state_q == EMPTY || out_ready_i) && found && !flush_i;
    state_d = state_q;
    out_rec_d = out_rec_q;
    out_id_d = out_id_q;
    last_d = last_q;
    if (flush_i) state_d = EMPTY;
    else if (load) begin
      state_d = HOLD;
      out_rec_d = mem_q[grant][rd_q[grant]];
      out_id_d = grant;
      last_d = grant;
    end else if (state_q == HOLD && out_ready_i) state_d = EMPTY;
  end
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      pop[k] = load && grant == IDW'(k);
      wr_d[k] = flush_i ? '0 : wr_q[k] + PW'(push[k]);
      rd_d[k] = flush_i ? '0 : rd_q[k] + PW'(pop[k]);
      cnt_d[k] = flush_i ? '0 : cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      drop_d[k] = (drop[k] && drop_q[k] != 16'hFFFF) ? drop_q[k] + 16'd1 : drop_q[k];
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      out_rec_q <= '0;
      out_id_q <= '0;
      last_q <= IDW'(NUM_REQ - 1);
      for (int k = 0; k < NUM_REQ; k++) begin
        wr_q[k] <= '0;
        rd_q[k] <= '0;
        cnt_q[k] <= '0;
        drop_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      out_rec_q <= out_rec_d;
      out_id_q <= out_id_d;
      last_q <= last_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        wr_q[k] <= wr_d[k];
        rd_q[k] <= rd_d[k];
        cnt_q[k] <= cnt_d[k];
        drop_q[k] <= drop_d[k];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++)
      if (push[k]) mem_q[k][wr_q[k]] <= req_rec_i[k*REC_W +: REC_W];
  end
  assign req_ready_o = ~full;
  assign out_valid_o = state_q == HOLD;
  assign out_rec_o = out_rec_q;
  assign out_id_o = out_id_q;
endmodule

// File: doc/rvvi_trace_arbiter.md
RVVI_TRACE_ARBITER -- requirements
Module: rvvi_trace_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of retirement-record requesters (harts); the legal range is 2..4.
REQ-002 The block SHALL have parameter REC_W, default 97, giving the opaque record width (pc, insn, wdata, trap).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the per-requester FIFO depth; it SHALL be a power of two, at least 2.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous clear of all buffered records.
REQ-007 The block SHALL have port req_valid_i, input, NUM_REQ bits: one record offered per requester.
REQ-008 The block SHALL have port req_rec_i, input, NUM_REQ x REC_W bits: the offered records.
REQ-009 The block SHALL have port req_ready_o, input-side handshake output, NUM_REQ bits: requester FIFO not full.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: output record valid.
REQ-011 The block SHALL have port out_rec_o, output, REC_W bits: granted record.
REQ-012 The block SHALL have port out_id_o, output, $clog2(NUM_REQ) bits: source requester index of out_rec_o.
REQ-013 The block SHALL have port out_ready_i, input, 1 bit: sink accepts the record.
REQ-014 The block SHALL have port drop_cnt_o, output, NUM_REQ x 16 bits: per-requester dropped-record counters.

Function
REQ-015 A push SHALL occur when req_valid_i[k] and req_ready_o[k] are both 1 at a rising edge.
REQ-016 req_ready_o[k] SHALL equal 1 exactly when FIFO k is not full; a pop in the same cycle SHALL NOT make a full FIFO ready (registered, pop-independent).
REQ-017 When req_valid_i[k]=1 and req_ready_o[k]=0, the record SHALL be discarded and drop_cnt_o[k] SHALL increment by 1, saturating at 16'hFFFF.
REQ-018 Each FIFO SHALL preserve per-requester order; its pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with DEPTH+1 states.
REQ-019 The output stage SHALL be a single register with two states:
- EMPTY: out_valid_o=0.
- HOLD: out_valid_o=1.
REQ-020 The output register SHALL load when it is EMPTY, or when it is in HOLD with out_ready_i=1, provided at least one FIFO is non-empty; this gives full throughput of one record per cycle.
REQ-021 In HOLD with out_ready_i=0, out_rec_o and out_id_o SHALL remain stable and no FIFO SHALL be popped.
REQ-022 Arbitration SHALL be round-robin over non-empty FIFOs, searching from index (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-023 last_grant SHALL update only on a load, to the granted index.
REQ-024 Exactly one FIFO SHALL be popped per load; it SHALL be the granted one.
REQ-025 Latency: a record pushed at edge E into an empty block with an EMPTY output SHALL be presented on out_valid_o/out_rec_o after edge E+1.
REQ-026 A simultaneous push and pop on the same non-full FIFO SHALL leave its occupancy unchanged.
REQ-027 In HOLD with out_ready_i=1 and all FIFOs empty, the output SHALL go to EMPTY.
REQ-028 flush_i=1 SHALL, at the next edge:
- empty all FIFOs;
- set the output to EMPTY;
- ignore pushes in that cycle;
- leave drop_cnt_o and last_grant unchanged.
REQ-029 Inputs sampled while flush_i=1 SHALL NOT count as drops.

Reset
REQ-030 While rst_n_i=0, regardless of the clock, the block SHALL hold:
- out_valid_o=0;
- out_rec_o=0;
- out_id_o=0;
- all FIFOs empty;
- req_ready_o all 1s;
- drop_cnt_o all 0;
- last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered and held records; the first grant after release SHALL follow REQ-030.

Verification
REQ-032 Single push: push 0xA5 on requester 0 at edge 1, out_ready_i=1 -> out_valid_o=1, out_rec_o=0xA5, out_id_o=0 after edge 2; out_valid_o=0 after edge 3.
REQ-033 Fairness: both requesters hold valid every cycle with distinct sequences, out_ready_i=1 -> out_id_o alternates 0,1,0,1 starting with 0, and each stream stays in order.
REQ-034 Back-pressure: out_ready_i=0 for 10 cycles while requester 1 pushes every cycle -> 4 accepted (FIFO full), 1 held in the output register, req_ready_o[1]=0, drop_cnt_o[1]=5; releasing out_ready_i yields the 5 buffered records in order.
REQ-035 Saturation: force 70000 drops on requester 0 -> drop_cnt_o[0]=16'hFFFF and stays there.
REQ-036 Flush: flush_i pulse with 3 records buffered and the output in HOLD -> out_valid_o=0 and req_ready_o all 1 next cycle, drop counters unchanged.
REQ-037 Reset: assert rst_n_i=0 asynchronously mid-HOLD -> out_valid_o=0 immediately; after release, the first grant goes to requester 0.
